// File: rtl/accel_wb_ctrl_pkg.sv
// Shared constants for the accelerator command controller: register offsets,
// register bit positions, buffer depths and the sequencing FSM state type.
package accel_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_IN_BASE  = 8'h40;
  localparam logic [7:0] OFF_OUT_BASE = 8'h80;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;

  localparam int IN_BUF_DEPTH  = 16;
  localparam int OUT_BUF_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    UNLOAD
  } accel_state_t;

endpackage

// File: rtl/accel_wb_ctrl_regif.sv
// Wishbone classic slave front end: address decode, single-cycle registered ack,
// registered read mux, and write strobes issued in the cycle the ack is visible.
module accel_wb_regif
  import accel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        irq_en_i,
  input  logic [2:0]  status_i,
  input  logic [31:0] in_buf_i  [IN_BUF_DEPTH],
  input  logic [31:0] out_buf_i [OUT_BUF_DEPTH],
  output logic        ctrl_wr_o,
  output logic        status_wr_o,
  output logic        in_wr_o,
  output logic [3:0]  in_idx_o,
  output logic [31:0] wr_mask_o,
  output logic [31:0] wr_dat_o
);

  // Misaligned offsets fall through to "unmapped" so they read 0 and drop writes.
  function automatic logic is_in(input logic [7:0] off);
    return (off[7:6] == OFF_IN_BASE[7:6]) && (off[1:0] == 2'b00);
  endfunction

  function automatic logic is_out(input logic [7:0] off);
    return (off[7:5] == OFF_OUT_BASE[7:5]) && (off[1:0] == 2'b00);
  endfunction

  logic        ack_q, we_q, req, wr;
  logic [7:0]  off, off_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q, rdat_q, rdat_d;

  assign off = wbs_adr_i[7:0];
  assign req = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  always_comb begin
    rdat_d = '0;
    if (off == OFF_CTRL)        rdat_d[CTRL_IRQ_EN] = irq_en_i;
    else if (off == OFF_STATUS) rdat_d[2:0] = status_i;
    else if (is_in(off))        rdat_d = in_buf_i[off[5:2]];
    else if (is_out(off))       rdat_d = out_buf_i[off[4:2]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      we_q   <= 1'b0;
      off_q  <= '0;
      sel_q  <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) begin
        we_q  <= wbs_we_i;
        off_q <= off;
        sel_q <= wbs_sel_i;
        dat_q <= wbs_dat_i;
        if (!wbs_we_i) rdat_q <= rdat_d;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;

  assign wr          = ack_q & we_q;
  assign ctrl_wr_o   = wr && (off_q == OFF_CTRL);
  assign status_wr_o = wr && (off_q == OFF_STATUS);
  assign in_wr_o     = wr && is_in(off_q);
  assign in_idx_o    = off_q[5:2];
  assign wr_dat_o    = dat_q;
  assign wr_mask_o   = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};

endmodule

// File: rtl/accel_wb_ctrl.sv
// Command controller that streams the IN buffer into the crypto core and captures
// its result words. Define ACCEL_CTRL_TIMEOUT_EN to build in the stall watchdog.
module accel_wb_ctrl
  import accel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          IN_WORDS    = 16,
  parameter int          OUT_WORDS   = 8,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] core_in_data,
  output logic        core_in_valid,
  input  logic        core_in_ready,
  input  logic [31:0] core_out_data,
  input  logic        core_out_valid,
  output logic        irq
);

  if (IN_WORDS < 1 || IN_WORDS > IN_BUF_DEPTH) begin : g_bad_in_words
    $error("IN_WORDS must be 1..16");
  end
  if (OUT_WORDS < 1 || OUT_WORDS > OUT_BUF_DEPTH) begin : g_bad_out_words
    $error("OUT_WORDS must be 1..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end

  localparam logic [3:0] IN_LAST  = 4'(IN_WORDS - 1);
  localparam logic [2:0] OUT_LAST = 3'(OUT_WORDS - 1);

  accel_state_t state_q, state_d;
  logic [3:0]  idx_q, idx_d, in_idx;
  logic [2:0]  oidx_q, oidx_d;
  logic        done_q, done_d, irq_en_q, irq_en_d;
  logic        busy, in_xfer, out_xfer, start, abort, timeout, wdog_hit;
  logic        ctrl_wr, status_wr, in_wr;
  logic [31:0] wr_mask, wr_dat;
  logic [31:0] in_buf_q  [IN_BUF_DEPTH];
  logic [31:0] out_buf_q [OUT_BUF_DEPTH];

  accel_wb_regif #(.BASE_ADDR(BASE_ADDR)) u_regif (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .irq_en_i    (irq_en_q),
    .status_i    ({timeout, done_q, busy}),
    .in_buf_i    (in_buf_q),
    .out_buf_i   (out_buf_q),
    .ctrl_wr_o   (ctrl_wr),
    .status_wr_o (status_wr),
    .in_wr_o     (in_wr),
    .in_idx_o    (in_idx),
    .wr_mask_o   (wr_mask),
    .wr_dat_o    (wr_dat)
  );

  assign busy          = (state_q != IDLE);
  assign in_xfer       = (state_q == LOAD) && core_in_ready;
  assign out_xfer      = ((state_q == RUN) || (state_q == UNLOAD)) && core_out_valid;
  assign start         = ctrl_wr && wr_mask[CTRL_START] && wr_dat[CTRL_START];
  assign abort         = ctrl_wr && wr_mask[CTRL_ABORT] && wr_dat[CTRL_ABORT];
  assign core_in_valid = (state_q == LOAD);
  assign core_in_data  = (state_q == LOAD) ? in_buf_q[idx_q] : '0;

  // Abort outranks everything; a DONE set outranks a same-cycle W1C of DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    oidx_d   = oidx_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr && wr_mask[CTRL_IRQ_EN]) irq_en_d = wr_dat[CTRL_IRQ_EN];
    if (status_wr && wr_mask[ST_DONE] && wr_dat[ST_DONE]) done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          oidx_d  = '0;
          done_d  = 1'b0;
        end
        LOAD: if (core_in_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == IN_LAST) state_d = RUN;
        end
        RUN, UNLOAD: if (core_out_valid) begin
          oidx_d  = oidx_q + 3'd1;
          state_d = UNLOAD;
          if (oidx_q == OUT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (wdog_hit) state_d = IDLE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      oidx_q   <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      oidx_q   <= oidx_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < IN_BUF_DEPTH; i++) in_buf_q[i] <= '0;
      for (int i = 0; i < OUT_BUF_DEPTH; i++) out_buf_q[i] <= '0;
    end else begin
      if (in_wr && !busy) in_buf_q[in_idx] <= (in_buf_q[in_idx] & ~wr_mask) | (wr_dat & wr_mask);
      if (out_xfer && !abort) out_buf_q[oidx_q] <= core_out_data;
    end
  end

`ifdef ACCEL_CTRL_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  // Counter restarts on every word transfer; state entries always coincide with one.
  always_comb begin
    wdog_d    = '0;
    timeout_d = timeout_q;
    wdog_hit  = 1'b0;
    if (status_wr && wr_mask[ST_TIMEOUT] && wr_dat[ST_TIMEOUT]) timeout_d = 1'b0;
    if (busy && !abort && !in_xfer && !out_xfer) begin
      if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
        wdog_hit  = 1'b1;
        timeout_d = 1'b1;
      end else begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
  assign irq     = (done_q | timeout_q) & irq_en_q;
`else
  assign timeout  = 1'b0;
  assign wdog_hit = 1'b0;
  assign irq      = done_q & irq_en_q;
`endif

endmodule
